hdmi_config: RTL and testbench

Power-up configuration sequencer for the HDMI transmitter (ADV7511-class) attached to the `video` output block. On `start` it walks a fixed table of register/value pairs and writes each over an open-drain I2C master it implements itself: single-master, write-only, no clock stretching. It reports `done` when the table completes, and `err` if a write is never acknowledged. `video` must not be enabled until `done` is high.

---
 rtl/hdmi_cfg_pkg.sv | 39 +++
 rtl/hdmi_config_i2c_bit_engine.sv | 105 ++++++++++
 rtl/hdmi_config.sv | 181 ++++++++++++++++++
 tb/tb_hdmi_config.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_cfg_pkg.sv
// Shared types and register table for the HDMI transmitter
// power-up configuration sequencer.
package hdmi_cfg_pkg;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] val;
    } cfg_entry_t;

    localparam int CFG_LEN = 11;

    // Input ID 5, RGB 4:4:4 with separate syncs, 8-bit, rising first edge
    localparam cfg_entry_t CFG_TABLE [CFG_LEN] = '{
        '{8'h41, 8'h10},
        '{8'h98, 8'h03},
        '{8'h9A, 8'hE0},
        '{8'h9C, 8'h30},
        '{8'h9D, 8'h61},
        '{8'hA2, 8'hA4},
        '{8'hA3, 8'hA4},
        '{8'hE0, 8'hD0},
        '{8'hF9, 8'h00},
        '{8'h15, 8'h05},
        '{8'h16, 8'h36}
    };

    typedef enum logic [2:0] {
        S_IDLE, S_XFER, S_CHECK, S_FIN, S_FAIL
    } cfg_state_t;

    typedef enum logic [2:0] {
        CMD_START, CMD_BIT0, CMD_BIT1, CMD_RX_ACK, CMD_STOP, CMD_GAP
    } i2c_cmd_t;

    typedef enum logic [1:0] {
        PH_START, PH_DATA, PH_STOP, PH_GAP
    } xfer_ph_t;

endpackage

// File: rtl/hdmi_config_i2c_bit_engine.sv
// Executes one I2C slot (START, data bit, ACK, STOP or gap) of
// four CLK_DIV-cycle quarters and drives the open-drain enables.
module i2c_bit_engine
    import hdmi_cfg_pkg::*;
#(
    parameter int CLK_DIV = 125
) (
    input  logic     clk,
    input  logic     rst,
    input  i2c_cmd_t i_cmd,
    input  logic     i_valid,
    output logic     o_rdy,
    output logic     o_slot_done,
    output logic     o_ack_n,
    output logic     o_scl_oe,
    output logic     o_sda_oe,
    input  logic     i_sda
);

    localparam int DW = $clog2(CLK_DIV);

    logic [DW-1:0] r_div;
    logic [1:0]    r_q;
    logic          r_act;
    i2c_cmd_t      r_cmd;
    logic [1:0]    r_sync;
    logic          r_ack_n;

    logic w_qend;
    logic w_last;
    logic w_sample;
    logic w_low;

    assign w_qend      = (r_div == DW'(CLK_DIV - 1));
    assign w_last      = r_act && w_qend && (r_q == 2'd3);
    assign w_sample    = r_act && w_qend && (r_q == 2'd2)
                         && (r_cmd == CMD_RX_ACK);
    assign w_low       = (r_q == 2'd0) || (r_q == 2'd3);
    assign o_rdy       = !r_act || w_last;
    assign o_slot_done = w_last;
    assign o_ack_n     = r_ack_n;

    // Idle bus reads high, so the synchronizer resets to 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_sda};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_act   <= 1'b0;
            r_cmd   <= CMD_GAP;
            r_div   <= '0;
            r_q     <= '0;
            r_ack_n <= 1'b0;
        end else if (i_valid && o_rdy) begin
            r_act   <= 1'b1;
            r_cmd   <= i_cmd;
            r_div   <= '0;
            r_q     <= '0;
            r_ack_n <= 1'b0;
        end else if (r_act) begin
            if (w_sample) r_ack_n <= r_sync[1];
            if (w_last) r_act <= 1'b0;
            if (w_qend) begin
                r_div <= '0;
                r_q   <= r_q + 2'd1;
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    always_comb begin
        o_scl_oe = 1'b0;
        o_sda_oe = 1'b0;
        if (r_act) begin
            unique case (r_cmd)
                CMD_START: begin
                    o_sda_oe = r_q[1];
                    o_scl_oe = (r_q == 2'd3);
                end
                CMD_BIT0: begin
                    o_sda_oe = 1'b1;
                    o_scl_oe = w_low;
                end
                CMD_BIT1, CMD_RX_ACK: begin
                    o_scl_oe = w_low;
                end
                CMD_STOP: begin
                    o_sda_oe = !r_q[1];
                    o_scl_oe = (r_q == 2'd0);
                end
                default: begin
                    o_scl_oe = 1'b0;
                    o_sda_oe = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hdmi_config.sv
// Walks the HDMI transmitter register table over a write-only I2C
// master, retrying NACKed entries, and reports done or err.
module hdmi_config
    import hdmi_cfg_pkg::*;
#(
    parameter int         CLK_DIV   = 125,
    parameter logic [6:0] DEV_ADDR  = 7'h39,
    parameter int         RETRY_MAX = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] err_idx,
    output logic       HDMI_SCL_OE,
    output logic       HDMI_SDA_OE,
    input  logic       HDMI_SDA_IN
);

    localparam int RW = $clog2(RETRY_MAX + 2);

    cfg_state_t    r_state;
    cfg_state_t    w_next;
    logic [3:0]    r_idx;
    logic [RW-1:0] r_retry;
    xfer_ph_t      r_ph;
    logic [1:0]    r_byte;
    logic [3:0]    r_bit;
    logic          r_nack;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic [3:0]    r_err_idx;

    cfg_entry_t w_ent;
    i2c_cmd_t   w_cmd;
    logic [7:0] w_byte;
    logic       w_valid;
    logic       w_rdy;
    logic       w_accept;
    logic       w_slot_done;
    logic       w_ack_n;
    logic       w_last;
    logic       w_retry_out;

    assign w_ent       = CFG_TABLE[r_idx];
    assign w_valid     = (r_state == S_XFER);
    assign w_accept    = w_valid && w_rdy;
    assign w_last      = (r_idx == 4'(CFG_LEN - 1));
    assign w_retry_out = (int'(r_retry) + 1) > RETRY_MAX;

    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;
    assign err_idx = r_err_idx;

    always_comb begin
        w_byte = w_ent.val;
        unique case (r_byte)
            2'd0:    w_byte = {DEV_ADDR, 1'b0};
            2'd1:    w_byte = w_ent.addr;
            default: w_byte = w_ent.val;
        endcase
    end

    always_comb begin
        w_cmd = CMD_GAP;
        unique case (r_ph)
            PH_START: w_cmd = CMD_START;
            PH_DATA: begin
                if (r_bit == 4'd8) w_cmd = CMD_RX_ACK;
                else if (w_byte[~r_bit[2:0]]) w_cmd = CMD_BIT1;
                else w_cmd = CMD_BIT0;
            end
            PH_STOP:  w_cmd = CMD_STOP;
            PH_GAP:   w_cmd = CMD_GAP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // CHECK runs while the gap slot is still on the bus, so the next
    // START issues back-to-back; FIN/FAIL wait for that gap to end
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_XFER;
            S_XFER:  if (w_accept && r_ph == PH_GAP) w_next = S_CHECK;
            S_CHECK: begin
                if (r_nack) w_next = w_retry_out ? S_FAIL : S_XFER;
                else        w_next = w_last ? S_FIN : S_XFER;
            end
            S_FIN, S_FAIL: if (w_slot_done) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx     <= '0;
            r_retry   <= '0;
            r_ph      <= PH_START;
            r_byte    <= '0;
            r_bit     <= '0;
            r_nack    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_err_idx <= '0;
        end else begin
            if (w_slot_done && w_ack_n) r_nack <= 1'b1;
            if (r_state == S_IDLE && start) begin
                r_idx   <= '0;
                r_retry <= '0;
                r_ph    <= PH_START;
                r_busy  <= 1'b1;
                r_done  <= 1'b0;
                r_err   <= 1'b0;
            end
            if (w_accept) begin
                unique case (r_ph)
                    PH_START: begin
                        r_ph   <= PH_DATA;
                        r_byte <= '0;
                        r_bit  <= '0;
                        r_nack <= 1'b0;
                    end
                    PH_DATA: begin
                        if (r_bit == 4'd8) begin
                            r_bit <= '0;
                            if (r_byte == 2'd2) r_ph <= PH_STOP;
                            else r_byte <= r_byte + 2'd1;
                        end else begin
                            r_bit <= r_bit + 4'd1;
                        end
                    end
                    PH_STOP:  r_ph <= PH_GAP;
                    PH_GAP:   r_ph <= PH_START;
                endcase
            end
            if (r_state == S_CHECK) begin
                if (r_nack) begin
                    if (!w_retry_out) r_retry <= r_retry + 1'b1;
                end else begin
                    r_retry <= '0;
                    if (!w_last) r_idx <= r_idx + 4'd1;
                end
            end
            if (r_state == S_FIN && w_slot_done) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
            if (r_state == S_FAIL && w_slot_done) begin
                r_err     <= 1'b1;
                r_err_idx <= r_idx;
                r_busy    <= 1'b0;
            end
        end
    end

    i2c_bit_engine #(
        .CLK_DIV(CLK_DIV)
    ) u_eng (
        .clk        (clk),
        .rst        (rst),
        .i_cmd      (w_cmd),
        .i_valid    (w_valid),
        .o_rdy      (w_rdy),
        .o_slot_done(w_slot_done),
        .o_ack_n    (w_ack_n),
        .o_scl_oe   (HDMI_SCL_OE),
        .o_sda_oe   (HDMI_SDA_OE),
        .i_sda      (HDMI_SDA_IN)
    );

endmodule

// File: tb/tb_hdmi_config.sv
// Bench for hdmi_config: I2C slave/bus monitor plus a table-level
// model of expected transactions, retries and completion time.
module tb_hdmi_config;

    localparam int DIV  = 4;
    localparam int TRX  = 120 * DIV;
    localparam int RMAX = 3;
    localparam logic [15:0] TBL [11] = '{
        16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61, 16'hA2A4,
        16'hA3A4, 16'hE0D0, 16'hF900, 16'h1505, 16'h1636
    };

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, err;
    logic [3:0] err_idx;
    logic       scl_oe, sda_oe, sda_in;
    logic       pull = 1'b0;

    assign sda_in = !(sda_oe || pull);

    hdmi_config #(
        .CLK_DIV  (DIV),
        .DEV_ADDR (7'h39),
        .RETRY_MAX(RMAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_idx    (err_idx),
        .HDMI_SCL_OE(scl_oe),
        .HDMI_SDA_OE(sda_oe),
        .HDMI_SDA_IN(sda_in)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: per-entry NACK budgets -> transaction list
    int          cnt [11][3];
    logic [23:0] exp_q [$];
    logic [2:0]  mask_q [$];
    bit          exp_err;
    int          exp_idx;

    function automatic void plan();
        int c [11][3];
        int e, r;
        logic [2:0] m;
        c = cnt;
        exp_q.delete();
        mask_q.delete();
        exp_err = 0;
        exp_idx = 0;
        e = 0;
        r = 0;
        while (e < 11) begin
            m = 3'b000;
            for (int b = 0; b < 3; b++)
                if (c[e][b] > 0) begin
                    c[e][b]--;
                    m[b] = 1'b1;
                end
            exp_q.push_back({8'h72, TBL[e]});
            mask_q.push_back(m);
            if (m == 3'b000) begin
                e++;
                r = 0;
            end else begin
                r++;
                if (r > RMAX) begin
                    exp_err = 1;
                    exp_idx = e;
                    break;
                end
            end
        end
    endfunction

    function automatic void clr();
        for (int i = 0; i < 11; i++)
            for (int b = 0; b < 3; b++) cnt[i][b] = 0;
    endfunction

    // Slave / bus monitor
    logic [23:0] rx_q [$];
    int          t_ord = 0, prot_err = 0, hi_err = 0;
    int          bitc = 0, bytec = 0, hi = 0;
    logic        scl_l, sda_l, prev_scl = 1'b1, prev_sda = 1'b1;
    logic        acking = 1'b0, in_x = 1'b0, cond = 1'b1;
    logic [7:0]  sh = '0;
    logic [23:0] cur = '0;

    initial begin
        forever begin
            @(negedge clk);
            scl_l = !scl_oe;
            sda_l = sda_in;
            if (rst) begin
                pull = 1'b0; acking = 1'b0; in_x = 1'b0;
                bitc = 0; bytec = 0; cond = 1'b1;
            end else begin
                if (scl_l && prev_scl && prev_sda && !sda_l) begin
                    if (in_x) prot_err++;
                    in_x = 1'b1; bitc = 0; bytec = 0;
                    acking = 1'b0; cond = 1'b1; cur = '0;
                end else if (scl_l && prev_scl && !prev_sda && sda_l) begin
                    if (!in_x || bytec != 3 || bitc > 1) prot_err++;
                    else rx_q.push_back(cur);
                    in_x = 1'b0; cond = 1'b1; t_ord++;
                end
                if (scl_l && !prev_scl) begin
                    hi = 1;
                    cond = 1'b0;
                    if (in_x && !acking && bitc < 8) begin
                        sh = {sh[6:0], sda_l};
                        bitc++;
                    end
                end else if (scl_l) begin
                    hi++;
                end
                if (!scl_l && prev_scl) begin
                    if (!cond && hi != 2 * DIV) hi_err++;
                    if (in_x) begin
                        if (acking) begin
                            pull = 1'b0; acking = 1'b0;
                            bitc = 0; bytec++;
                        end else if (bitc == 8) begin
                            cur = {cur[15:0], sh};
                            acking = 1'b1;
                            pull = (t_ord < mask_q.size() && bytec < 3)
                                   ? !mask_q[t_ord][bytec] : 1'b1;
                        end
                    end
                end
            end
            prev_scl = scl_l;
            prev_sda = sda_l;
        end
    end

    task automatic run_seq(input string nm, input int dup_at);
        int c0, lim, dt;
        plan();
        rx_q.delete();
        t_ord = 0; prot_err = 0; hi_err = 0;
        repeat ($urandom_range(2, 30)) @(posedge clk);
        #1 start = 1'b1;
        c0 = cyc;
        @(posedge clk);
        #1 start = 1'b0;
        check($sformatf("%s:busy_rise", nm), busy, 1);
        lim = 0;
        while (!(done || err) && lim < 20 * TRX) begin
            @(negedge clk);
            lim++;
            start = (dup_at > 0 && cyc - c0 == dup_at);
        end
        start = 1'b0;
        check($sformatf("%s:no_timeout", nm), lim < 20 * TRX, 1);
        dt = cyc - c0;
        check($sformatf("%s:end_cycle", nm), dt, exp_q.size() * TRX + 2);
        check($sformatf("%s:done", nm), done, !exp_err);
        check($sformatf("%s:err", nm), err, exp_err);
        check($sformatf("%s:busy_end", nm), busy, 0);
        if (exp_err) check($sformatf("%s:err_idx", nm), err_idx, exp_idx);
        repeat (5) @(negedge clk);
        check($sformatf("%s:scl_rel", nm), scl_oe, 0);
        check($sformatf("%s:sda_rel", nm), sda_oe, 0);
        check($sformatf("%s:n_trx", nm), rx_q.size(), exp_q.size());
        check($sformatf("%s:protocol", nm), prot_err, 0);
        check($sformatf("%s:scl_high", nm), hi_err, 0);
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("%s:trx%0d", nm, i), rx_q[i], exp_q[i]);
    endtask

    initial begin
        int c0;
        clr();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst:busy", busy, 0);
        check("rst:done", done, 0);
        check("rst:err", err, 0);
        check("rst:err_idx", err_idx, 0);
        check("rst:scl_oe", scl_oe, 0);
        check("rst:sda_oe", sda_oe, 0);
        rst = 1'b0;

        clr(); run_seq("all_ack", 0);
        clr(); cnt[3][2] = 1; run_seq("nack_once", 0);
        clr(); cnt[0][0] = 1000; run_seq("nack_always", 0);

        clr(); plan();
        rx_q.delete(); t_ord = 0;
        @(posedge clk);
        #1 start = 1'b1;
        c0 = cyc;
        @(posedge clk);
        #1 start = 1'b0;
        do begin
            @(posedge clk);
            #1;
        end while (cyc - c0 < 700);
        check("rst_mid:active", busy, 1);
        rst = 1'b1;
        #1;
        check("rst_mid:scl_oe", scl_oe, 0);
        check("rst_mid:sda_oe", sda_oe, 0);
        check("rst_mid:busy", busy, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        run_seq("rst_restart", 0);

        clr(); run_seq("busy_start", 1000);

        for (int k = 0; k < 3; k++) begin
            clr();
            repeat (2)
                cnt[$urandom_range(0, 10)][$urandom_range(0, 2)] =
                    $urandom_range(1, 4);
            run_seq($sformatf("rand%0d", k), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
